// File: rtl/wavelet_tap_buffer.sv
// -----------------------------------------------------------------------------
// wavelet_tap_buffer
//
// Upstream feeder for a wavelet FIR stage. Accepted samples are shifted into a
// NUM_ELEM-deep sliding window, which is presented as a packed tap vector.
// When the window is full, a one-cycle start strobe is issued. After that, a
// strobe is issued once every DECIMATE accepted samples. All FIRs that share
// the same window can be driven by a single instance.
//
// Parameters:
//   BITS_PER_ELEM  width of one signed sample (matches the FIR)
//   NUM_ELEM       window depth in samples, >= 2 (matches the FIR)
//   DECIMATE       accepted samples per start strobe once primed, >= 1
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous reset, active low
//   i_value        incoming sample (passed through bit-exact, sign included)
//   i_value_valid  i_value is accepted on every rising edge where this is high
//   i_clear        synchronous flush of the window and the counters;
//                  takes priority over i_value_valid
//   o_taps         packed window: element 0 (LSBs) is the newest sample,
//                  element NUM_ELEM-1 is the oldest sample
//   o_start_calc   one-cycle strobe for the FIR's i_start_calc input
//   o_primed       high once NUM_ELEM samples have been accepted since
//                  reset or clear
// -----------------------------------------------------------------------------
module wavelet_tap_buffer #(
  parameter int BITS_PER_ELEM = 8,
  parameter int NUM_ELEM      = 7,
  parameter int DECIMATE      = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [BITS_PER_ELEM-1:0]          i_value,
  input  logic                              i_value_valid,
  input  logic                              i_clear,
  output logic [NUM_ELEM*BITS_PER_ELEM-1:0] o_taps,
  output logic                              o_start_calc,
  output logic                              o_primed
);

  localparam int TAPS_W = NUM_ELEM * BITS_PER_ELEM;
  localparam int FILL_W = $clog2(NUM_ELEM + 1);
  localparam int DEC_W  = $clog2(DECIMATE) + 1;

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(NUM_ELEM - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NUM_ELEM);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECIMATE - 1);
  localparam logic [DEC_W-1:0]  DEC_ONE   = DEC_W'(1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_reg;
  logic [TAPS_W-1:0]   taps_reg;
  logic [TAPS_W-1:0]   taps_shift_next;
  logic [FILL_W-1:0]   fill_cnt_reg;
  logic [DEC_W-1:0]    dec_cnt_reg;
  logic                start_reg;
  logic                primed_reg;

  // Window after one accept. Each element takes the value of its younger
  // neighbour, and the new sample lands in element 0.
  assign taps_shift_next[BITS_PER_ELEM-1:0] = i_value;

  generate
    for (genvar gi = 1; gi < NUM_ELEM; gi++) begin : g_shift
      assign taps_shift_next[gi*BITS_PER_ELEM +: BITS_PER_ELEM] =
        taps_reg[(gi-1)*BITS_PER_ELEM +: BITS_PER_ELEM];
    end
  endgenerate

  // The window, the counters, the FSM and both flags all update on the same
  // edge. While o_start_calc is high, o_taps therefore already holds the
  // sample that triggered the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_FILL;
      taps_reg     <= '0;
      fill_cnt_reg <= '0;
      dec_cnt_reg  <= '0;
      start_reg    <= 1'b0;
      primed_reg   <= 1'b0;
    end else if (i_clear) begin
      // A sample that arrives in the same cycle as a clear is discarded.
      state_reg    <= ST_FILL;
      taps_reg     <= '0;
      fill_cnt_reg <= '0;
      dec_cnt_reg  <= '0;
      start_reg    <= 1'b0;
      primed_reg   <= 1'b0;
    end else begin
      // The strobe lasts one cycle. It is set again only by the accept
      // that qualifies for a strobe.
      start_reg <= 1'b0;
      if (i_value_valid) begin
        taps_reg <= taps_shift_next;
        unique case (state_reg)
          ST_FILL: begin
            if (fill_cnt_reg == FILL_LAST) begin
              // This accept completes the window.
              fill_cnt_reg <= FILL_FULL;
              state_reg    <= ST_RUN;
              primed_reg   <= 1'b1;
              start_reg    <= 1'b1;
            end else begin
              fill_cnt_reg <= fill_cnt_reg + FILL_ONE;
            end
          end
          ST_RUN: begin
            // In RUN, fill_cnt_reg stays saturated at NUM_ELEM. The
            // decimation phase restarts from 0 after the priming strobe.
            if (dec_cnt_reg == DEC_LAST) begin
              dec_cnt_reg <= '0;
              start_reg   <= 1'b1;
            end else begin
              dec_cnt_reg <= dec_cnt_reg + DEC_ONE;
            end
          end
          default: begin
            state_reg <= ST_FILL;
          end
        endcase
      end
    end
  end

  assign o_taps       = taps_reg;
  assign o_start_calc = start_reg;
  assign o_primed     = primed_reg;

endmodule

// File: tb/tb_wavelet_tap_buffer.sv
module tb_wavelet_tap_buffer;

  localparam int B  = 8;
  localparam int NE = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [B-1:0]    value = '0;
  logic            valid = 1'b0;
  logic            clear = 1'b0;

  logic [NE*B-1:0] taps_a, taps_b;
  logic            start_a, start_b, primed_a, primed_b;

  int vectors = 0;
  int fails   = 0;
  int txn     = 0;

  // Reference model: a history of accepted samples (newest first) and the
  // number of accepts since the last reset or clear.
  logic [B-1:0]    hist[$];
  int              n_acc = 0;
  logic [NE*B-1:0] exp_taps = '0;
  logic            exp_start_a = 1'b0, exp_start_b = 1'b0, exp_primed = 1'b0;

  always #5 clk = ~clk;

  wavelet_tap_buffer #(.BITS_PER_ELEM(B), .NUM_ELEM(NE), .DECIMATE(1)) dut (
    .clk(clk), .rst(rst), .i_value(value), .i_value_valid(valid), .i_clear(clear),
    .o_taps(taps_a), .o_start_calc(start_a), .o_primed(primed_a));

  wavelet_tap_buffer #(.BITS_PER_ELEM(B), .NUM_ELEM(NE), .DECIMATE(3)) dut_d3 (
    .clk(clk), .rst(rst), .i_value(value), .i_value_valid(valid), .i_clear(clear),
    .o_taps(taps_b), .o_start_calc(start_b), .o_primed(primed_b));

  // A strobe follows the accept that completes the window, then every dec-th
  // accept after that one.
  function automatic logic strobe_due(input int n, input int dec);
    if (n == NE) return 1'b1;
    if (n > NE)  return ((n - NE) % dec) == 0;
    return 1'b0;
  endfunction

  function automatic logic [NE*B-1:0] window_of_hist();
    logic [NE*B-1:0] w = '0;
    for (int k = 0; k < NE; k++)
      if (k < hist.size()) w[k*B +: B] = hist[k];
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    n_acc       = 0;
    exp_taps    = '0;
    exp_start_a = 1'b0;
    exp_start_b = 1'b0;
    exp_primed  = 1'b0;
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic apply(input logic v, input logic [B-1:0] val, input logic c);
    value = val;
    valid = v;
    clear = c;
    @(posedge clk);
    #1;
    if (c) begin
      model_reset();
    end else if (v) begin
      hist.push_front(val);
      if (hist.size() > NE) void'(hist.pop_back());
      n_acc++;
      exp_start_a = strobe_due(n_acc, 1);
      exp_start_b = strobe_due(n_acc, 3);
    end else begin
      exp_start_a = 1'b0;
      exp_start_b = 1'b0;
    end
    exp_primed = (n_acc >= NE);
    exp_taps   = window_of_hist();
    txn++;
    $display("txn %0d valid=%0b value=%h clear=%0b -> start=%0b/%0b primed=%0b taps=%h",
             txn, v, val, c, start_a, start_b, primed_a, taps_a);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({taps_a, start_a, primed_a, taps_b, start_b, primed_b} !== '0) begin
      fails++;
      $display("FAIL reset_init: got taps=%h/%h start=%0b/%0b primed=%0b/%0b, want all 0",
               taps_a, taps_b, start_a, start_b, primed_a, primed_b);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_fill_sequence();
    for (int s = 1; s <= 9; s++) begin
      apply(1'b1, B'(s), 1'b0);
      vectors++;
      if ({taps_a, start_a, primed_a} !== {exp_taps, exp_start_a, exp_primed}) begin
        fails++;
        $display("FAIL fill_seq s=%0d: got taps=%h start=%0b primed=%0b want taps=%h start=%0b primed=%0b",
                 s, taps_a, start_a, primed_a, exp_taps, exp_start_a, exp_primed);
      end
      if (s == 7) begin
        vectors++;
        if (taps_a !== 56'h01_02_03_04_05_06_07) begin
          fails++;
          $display("FAIL fill_window7: got %h want 01020304050607", taps_a);
        end
      end
    end
  endtask

  task automatic test_decimate();
    logic [12:0] got_mask = '0;
    apply(1'b0, 8'h00, 1'b1);
    for (int s = 0; s < 13; s++) begin
      apply(1'b1, B'($urandom), 1'b0);
      got_mask[s] = start_b;
      vectors++;
      if ({taps_b, start_b, primed_b} !== {exp_taps, exp_start_b, exp_primed}) begin
        fails++;
        $display("FAIL decimate s=%0d: got taps=%h start=%0b primed=%0b want taps=%h start=%0b primed=%0b",
                 s, taps_b, start_b, primed_b, exp_taps, exp_start_b, exp_primed);
      end
    end
    vectors++;
    if (got_mask !== 13'b1_0010_0100_0000) begin
      fails++;
      $display("FAIL decimate_mask: got %b want 1001001000000", got_mask);
    end
  endtask

  task automatic test_gaps();
    apply(1'b0, 8'h00, 1'b1);
    for (int s = 0; s < 7; s++) begin
      apply(1'b0, 8'h55, 1'b0);
      apply(1'b1, B'(8'h10 + s), 1'b0);
      vectors++;
      if ({taps_a, start_a, primed_a} !== {exp_taps, exp_start_a, exp_primed}) begin
        fails++;
        $display("FAIL gaps s=%0d: got taps=%h start=%0b primed=%0b want taps=%h start=%0b primed=%0b",
                 s, taps_a, start_a, primed_a, exp_taps, exp_start_a, exp_primed);
      end
      for (int k = 0; k < NE; k++) begin
        vectors++;
        if (taps_a[k*B +: B] === 8'h55) begin
          fails++;
          $display("FAIL gaps_leak elem=%0d: got 55 want not 55", k);
        end
      end
    end
  endtask

  task automatic test_clear();
    int strobes = 0;
    for (int s = 0; s < 9; s++) apply(1'b1, B'($urandom_range(1, 127)), 1'b0);
    apply(1'b1, 8'h80, 1'b1);
    vectors++;
    if ({taps_a, start_a, primed_a, taps_b, start_b, primed_b} !== '0) begin
      fails++;
      $display("FAIL clear_flush: got taps=%h start=%0b primed=%0b want all 0",
               taps_a, start_a, primed_a);
    end
    for (int s = 0; s < 7; s++) begin
      apply(1'b1, B'($urandom_range(1, 127)), 1'b0);
      if (s < 6 && start_a) strobes++;
      vectors++;
      if ({taps_a, start_a, primed_a} !== {exp_taps, exp_start_a, exp_primed}) begin
        fails++;
        $display("FAIL clear_refill s=%0d: got taps=%h start=%0b primed=%0b want taps=%h start=%0b primed=%0b",
                 s, taps_a, start_a, primed_a, exp_taps, exp_start_a, exp_primed);
      end
    end
    vectors++;
    if (strobes !== 0 || start_a !== 1'b1) begin
      fails++;
      $display("FAIL clear_strobe: got early=%0d last=%0b want early=0 last=1", strobes, start_a);
    end
  endtask

  task automatic test_negative();
    apply(1'b1, 8'h80, 1'b0);
    apply(1'b1, 8'hFF, 1'b0);
    vectors++;
    if (taps_a[15:0] !== 16'h80FF || taps_a !== exp_taps) begin
      fails++;
      $display("FAIL negative: got taps=%h want taps=%h (low 80FF)", taps_a, exp_taps);
    end
  endtask

  task automatic test_async_reset_mid();
    apply(1'b1, 8'h3C, 1'b0);
    #3 rst = 1'b0;
    #1;
    vectors++;
    if ({taps_a, start_a, primed_a, taps_b, start_b, primed_b} !== '0) begin
      fails++;
      $display("FAIL async_reset: got taps=%h start=%0b primed=%0b want all 0",
               taps_a, start_a, primed_a);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_random();
    for (int s = 0; s < 200; s++) begin
      apply(($urandom_range(0, 9) < 7), B'($urandom), ($urandom_range(0, 99) < 3));
      vectors++;
      if ({taps_a, start_a, primed_a, taps_b, start_b, primed_b} !==
          {exp_taps, exp_start_a, exp_primed, exp_taps, exp_start_b, exp_primed}) begin
        fails++;
        $display("FAIL random s=%0d: got taps=%h/%h start=%0b/%0b primed=%0b/%0b want taps=%h start=%0b/%0b primed=%0b",
                 s, taps_a, taps_b, start_a, start_b, primed_a, primed_b,
                 exp_taps, exp_start_a, exp_start_b, exp_primed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_sequence();
    test_decimate();
    test_gaps();
    test_clear();
    test_negative();
    test_random();
    test_async_reset_mid();
    test_fill_sequence();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
